// File: rtl/qpsk_demod.sv
// qpsk_demod: QPSK hard-decision demapper with a 2-entry output FIFO.
// Consumes {Im, Re} Q1.15 samples over a pipelined Wishbone-style stream and
// emits a 2-bit symbol {Re<0, Im<0} on a 6-bit output bus.
// Optional build macro QPSK_DEMOD_SOFT_EN adds a 4-bit reliability field
// (bits [14:11] of min(|Re|,|Im|)) on DAT_O[5:2]; otherwise DAT_O[5:2] is 0.
module qpsk_demod (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [5:0]  DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

`ifdef QPSK_DEMOD_SOFT_EN
    localparam int ENTRY_W = 6;
`else
    localparam int ENTRY_W = 2;
`endif

    logic               ena;
    logic               full;
    logic               push;
    logic               pop;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic               stb_reg;
    logic               cyc_reg;
    logic [ENTRY_W-1:0] mem_reg [0:1];
    logic [ENTRY_W-1:0] entry_next;

    assign ena   = CYC_I & STB_I & WE_I;
    assign full  = (count_reg == 2'd2);
    // Acceptance depends only on the current fill level, never on ACK_I
    assign ACK_O = ena & ~full;
    assign push  = ACK_O;
    assign pop   = stb_reg & ACK_I;

`ifdef QPSK_DEMOD_SOFT_EN
    // Magnitude of a Q1.15 value; the lone unrepresentable -1.0 saturates to max
    function automatic logic [14:0] sat_abs(input logic [15:0] v);
        logic [14:0] mag;
        if (!v[15])
            mag = v[14:0];
        else if (v == 16'h8000)
            mag = 15'h7FFF;
        else
            mag = ~v[14:0] + 15'd1;
        return mag;
    endfunction

    logic [14:0] re_mag;
    logic [14:0] im_mag;
    logic [14:0] min_mag;
    logic        unused_mag;

    assign re_mag     = sat_abs(DAT_I[15:0]);
    assign im_mag     = sat_abs(DAT_I[31:16]);
    assign min_mag    = (re_mag < im_mag) ? re_mag : im_mag;
    assign unused_mag = ^min_mag[10:0];
    // Sign bits give the quadrant; weaker axis magnitude gives the confidence
    assign entry_next = {min_mag[14:11], DAT_I[15], DAT_I[31]};
    assign DAT_O      = mem_reg[rd_ptr_reg];
`else
    logic unused_dat;

    assign unused_dat = ^{DAT_I[30:16], DAT_I[14:0]};
    // Sign bits alone give the quadrant; zero counts as non-negative
    assign entry_next = {DAT_I[15], DAT_I[31]};
    assign DAT_O      = {4'b0000, mem_reg[rd_ptr_reg]};
`endif

    // Fill level follows push/pop; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // One storage entry per pointer value; reset clears contents so DAT_O reads 0
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I)
                    mem_reg[gi] <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    mem_reg[gi] <= entry_next;
            end
        end
    endgenerate

    // Pointers, fill level and registered stream flags
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            stb_reg    <= 1'b0;
            cyc_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
            stb_reg   <= (count_next != 2'd0);
            // Keep the downstream cycle open until buffered symbols have drained
            cyc_reg   <= CYC_I | (count_next != 2'd0);
        end
    end

    assign STB_O = stb_reg;
    assign WE_O  = stb_reg;
    assign CYC_O = cyc_reg;

endmodule

// File: tb/tb_qpsk_demod.sv
// Self-checking bench for qpsk_demod: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the output buffer.
`timescale 1ns/1ps
module tb_qpsk_demod;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] DAT_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic        ACK_O;
    logic [5:0]  DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending symbols (capacity 2) and the CYC_O state
    logic [5:0] q[$];
    logic       cyc_m;

    qpsk_demod dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .DAT_I (DAT_I),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ACK_O (ACK_O),
        .DAT_O (DAT_O),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ACK_I (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic logic [5:0] ref_sym(input logic [31:0] x);
        int re, im, ar, ai, m;
        logic [3:0] rel;
        re = int'($signed(x[15:0]));
        im = int'($signed(x[31:16]));
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        if (ar > 32767) ar = 32767;
        if (ai > 32767) ai = 32767;
        m = (ar < ai) ? ar : ai;
`ifdef QPSK_DEMOD_SOFT_EN
        rel = 4'((m / 2048) % 16);
`else
        rel = 4'd0;
`endif
        return {rel, (re < 0), (im < 0)};
    endfunction

    function automatic logic exp_ack();
        return CYC_I && STB_I && WE_I && (q.size() < 2);
    endfunction

    task automatic drive(input logic c, input logic s, input logic w,
                         input logic [31:0] d, input logic a);
        CYC_I = c; STB_I = s; WE_I = w; DAT_I = d; ACK_I = a;
    endtask

    // Update the model from the inputs present before the edge, then clock
    task automatic advance();
        logic push, pop;
        if (RST_I) begin
            q.delete();
            cyc_m = 1'b0;
        end else begin
            push = exp_ack();
            pop  = (q.size() > 0) && ACK_I;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(ref_sym(DAT_I));
            cyc_m = CYC_I || (q.size() != 0);
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] s2;
        RST_I = 1'b1;
        drive(0, 0, 0, 32'h0, 0);
        q.delete(); cyc_m = 1'b0;
        #3;
        total++; if (STB_O !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", STB_O); end
        total++; if (CYC_O !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b exp=0", CYC_O); end
        total++; if (DAT_O !== 6'd0) begin bad++; $display("FAIL reset_dat got=%h exp=00", DAT_O); end
        total++; if (ACK_O !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ACK_O); end
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        // Fill both entries, then reset asynchronously in the middle of a cycle
        drive(1, 1, 1, 32'h8000_7FFF, 0); @(negedge CLK_I); advance();
        drive(1, 1, 1, 32'h1234_9ABC, 0); @(negedge CLK_I); advance();
        drive(0, 0, 0, 32'h0, 0);
        @(negedge CLK_I);
        total++; if (STB_O !== 1'b1) begin bad++; $display("FAIL prereset_stb got=%b exp=1", STB_O); end
        #2 RST_I = 1'b1;
        #1;
        total++; if (STB_O !== 1'b0) begin bad++; $display("FAIL midreset_stb got=%b exp=0", STB_O); end
        total++; if (CYC_O !== 1'b0) begin bad++; $display("FAIL midreset_cyc got=%b exp=0", CYC_O); end
        total++; if (DAT_O !== 6'd0) begin bad++; $display("FAIL midreset_dat got=%h exp=00", DAT_O); end
        q.delete(); cyc_m = 1'b0;
        advance();
        RST_I = 1'b0;
        s2 = 32'h0100_F000;
        drive(1, 1, 1, s2, 0); @(negedge CLK_I); advance();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge CLK_I);
        total++; if (STB_O !== 1'b1) begin bad++; $display("FAIL postreset_stb got=%b exp=1", STB_O); end
        total++; if (DAT_O !== ref_sym(s2)) begin bad++; $display("FAIL postreset_first got=%h exp=%h", DAT_O, ref_sym(s2)); end
        advance();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge CLK_I);
        total++; if (STB_O !== 1'b0) begin bad++; $display("FAIL postreset_stale got=%b exp=0", STB_O); end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_mapping();
        logic [31:0] samp [5];
        logic [1:0]  exp_s [5];
        samp = '{32'h5A82_5A82, 32'h5A82_A57E, 32'hA57E_5A82, 32'hA57E_A57E, 32'h0000_0000};
        exp_s = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(1, 1, 1, samp[i], 1);
            else       drive(0, 0, 0, 32'h0, 1);
            @(negedge CLK_I);
            if (i < 5) begin
                total++; if (ACK_O !== 1'b1) begin bad++; $display("FAIL map_ack[%0d] got=%b exp=1", i, ACK_O); end
            end
            if (i > 0) begin
                total++; if (STB_O !== 1'b1) begin bad++; $display("FAIL map_stb[%0d] got=%b exp=1", i-1, STB_O); end
                total++; if (DAT_O[1:0] !== exp_s[i-1]) begin bad++; $display("FAIL map_sym[%0d] got=%b exp=%b", i-1, DAT_O[1:0], exp_s[i-1]); end
            end
            advance();
        end
        $display("test_mapping done");
    endtask

    task automatic test_backpressure();
        logic [31:0] s [4];
        logic [5:0]  got[$];
        int idx, n;
        for (int i = 0; i < 4; i++) s[i] = $urandom;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 1, s[idx], 0);
            @(negedge CLK_I);
            total++; if (ACK_O !== (c < 2)) begin bad++; $display("FAIL bp_hold_ack[%0d] got=%b exp=%b", c, ACK_O, (c < 2)); end
            if (exp_ack()) idx++;
            advance();
        end
        n = 0;
        while ((idx < 4 || q.size() > 0) && n < 20) begin
            drive(idx < 4, idx < 4, 1, s[(idx < 4) ? idx : 3], 1);
            @(negedge CLK_I);
            if (n == 0) begin
                total++; if (ACK_O !== 1'b0) begin bad++; $display("FAIL bp_release_ack got=%b exp=0", ACK_O); end
            end
            total++; if (ACK_O !== exp_ack()) begin bad++; $display("FAIL bp_ack[%0d] got=%b exp=%b", n, ACK_O, exp_ack()); end
            if (STB_O === 1'b1) got.push_back(DAT_O);
            if (exp_ack()) idx++;
            advance();
            n++;
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== ref_sym(s[i])) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], ref_sym(s[i])); end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_simultaneous();
        logic [31:0] a, b;
        a = $urandom;
        b = a ^ 32'h8000_8000;
        drive(1, 1, 1, a, 0); @(negedge CLK_I); advance();
        drive(1, 1, 1, b, 1);
        @(negedge CLK_I);
        total++; if (ACK_O !== 1'b1) begin bad++; $display("FAIL simul_ack got=%b exp=1", ACK_O); end
        total++; if (DAT_O !== ref_sym(a)) begin bad++; $display("FAIL simul_old got=%h exp=%h", DAT_O, ref_sym(a)); end
        advance();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge CLK_I);
        total++; if (STB_O !== 1'b1) begin bad++; $display("FAIL simul_stb got=%b exp=1", STB_O); end
        total++; if (DAT_O !== ref_sym(b)) begin bad++; $display("FAIL simul_new got=%h exp=%h", DAT_O, ref_sym(b)); end
        advance();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge CLK_I);
        total++; if (STB_O !== 1'b0) begin bad++; $display("FAIL simul_empty got=%b exp=0", STB_O); end
        advance();
        $display("test_simultaneous done");
    endtask

    task automatic test_cyc_drain();
        logic exp_c [5];
        exp_c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(1, 1, 1, $urandom, 0); @(negedge CLK_I); advance();
        drive(1, 1, 1, $urandom, 0); @(negedge CLK_I); advance();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 32'h0, 1);
            @(negedge CLK_I);
            total++; if (CYC_O !== exp_c[c]) begin bad++; $display("FAIL drain_cyc[%0d] got=%b exp=%b", c, CYC_O, exp_c[c]); end
            advance();
        end
        $display("test_cyc_drain done");
    endtask

    task automatic test_soft();
        logic [5:0] e1, e2;
`ifdef QPSK_DEMOD_SOFT_EN
        e1 = 6'b000100;
        e2 = 6'b111110;
`else
        e1 = 6'b000000;
        e2 = 6'b000010;
`endif
        drive(1, 1, 1, 32'h0800_5A82, 1); @(negedge CLK_I); advance();
        drive(1, 1, 1, 32'h7FFF_8000, 1);
        @(negedge CLK_I);
        total++; if (DAT_O !== e1) begin bad++; $display("FAIL soft_small got=%b exp=%b", DAT_O, e1); end
        advance();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge CLK_I);
        total++; if (DAT_O !== e2) begin bad++; $display("FAIL soft_sat got=%b exp=%b", DAT_O, e2); end
        advance();
        $display("test_soft done");
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0:       d = 32'h8000_8000;
                1:       d = {16'h0000, 16'($urandom)};
                default: d = $urandom;
            endcase
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0, d, $urandom_range(0, 2) != 0);
            @(negedge CLK_I);
            total++; if (ACK_O !== exp_ack()) begin bad++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", c, ACK_O, exp_ack()); end
            total++; if (STB_O !== (q.size() != 0)) begin bad++; $display("FAIL rnd_stb[%0d] got=%b exp=%b", c, STB_O, (q.size() != 0)); end
            total++; if (WE_O !== (q.size() != 0)) begin bad++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, WE_O, (q.size() != 0)); end
            total++; if (CYC_O !== cyc_m) begin bad++; $display("FAIL rnd_cyc[%0d] got=%b exp=%b", c, CYC_O, cyc_m); end
            if (q.size() != 0) begin
                total++; if (DAT_O !== q[0]) begin bad++; $display("FAIL rnd_dat[%0d] got=%h exp=%h", c, DAT_O, q[0]); end
            end
            advance();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_backpressure();
        test_simultaneous();
        test_cyc_drain();
        test_soft();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_demod.md
# qpsk_demod

Receive-side QPSK hard-decision demapper. It is the counterpart of the transmit QPSK mapper.
- Accepts 32-bit complex samples {Im[31:16], Re[15:0]} (signed Q1.15) over the codebase's pipelined Wishbone-style streaming handshake.
- Slices each sample into a 2-bit symbol and buffers decisions in a 2-entry output FIFO.
- Emits the symbol on the 6-bit data bus used by the bit-level blocks upstream of the mapper.
- Sits between the receive FFT/equalizer output and the deinterleaver.

## Interface
- No parameters.
- CLK_I  in  1  sole clock, rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- DAT_I  in  32  sample; [15:0] Re, [31:16] Im, two's complement.
- CYC_I  in  1  upstream frame/cycle active.
- STB_I  in  1  upstream sample valid.
- WE_I  in  1  upstream write qualifier.
- ACK_O  out  1  sample accepted this cycle.
- DAT_O  out  6  [1:0] symbol {Re<0, Im<0}; [5:2] reliability (see Configuration).
- CYC_O  out  1  downstream cycle active.
- STB_O  out  1  DAT_O valid.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream accepted current DAT_O.

## Operation
- ena = CYC_I & STB_I & WE_I.
- ACK_O = ena & ~full. It is combinational and has no path from ACK_I.
- Push on ACK_O, pop on STB_O & ACK_I.
- Decision on push:
  - bit1 = DAT_I[15] (Re sign).
  - bit0 = DAT_I[31] (Im sign).
  - A zero value counts as non-negative and maps to 0.
  - This exactly inverts the transmit mapping: sample 0x5A82 maps to 0, sample 0xA57E maps to 1.
- FIFO:
  - 2 entries: write pointer and read pointer are 1 bit each; 2-bit count 0..2.
  - empty = (count==0), full = (count==2).
  - DAT_O = entry at read pointer, driven from registers (no combinational path from DAT_I).
  - STB_O = ~empty, registered.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Push is impossible when full.
- CYC_O is registered: next CYC_O = CYC_I | (next count != 0). This holds CYC_O high until buffered symbols drain after CYC_I drops.
- WE_O = STB_O.

## Timing
- Reset (asynchronous, immediate): STB_O=0, CYC_O=0, DAT_O=0, count=0, both pointers=0. ACK_O follows combinationally and is 0 only if no request is present.
- Reset mid-stream discards buffered symbols. The first push after RST_I falls lands in entry 0.
- Latency: a sample accepted at edge N has STB_O=1 with its symbol valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 sample/cycle sustained while ACK_I=1.
- Backpressure with ACK_I=0:
  - Two further samples are accepted, then ACK_O=0.
  - ACK_O reasserts in the cycle after the first pop.
- STB_O/DAT_O are held stable while STB_O=1 and ACK_I=0.
- Order is strictly preserved. Pointers wrap 1 to 0.
- ACK_I while STB_O=0 is ignored.
- STB_I without CYC_I or WE_I is ignored: no ACK_O, no push.

## Configuration
- Macro QPSK_DEMOD_SOFT_EN.
- Defined:
  - On push, compute |Re| and |Im|. -32768 saturates to 32767.
  - m = min(|Re|,|Im|).
  - Store m[14:11] alongside the decision. DAT_O[5:2] outputs it (0 = least reliable, 15 = most).
  - FIFO width becomes 6 bits.
- Undefined:
  - DAT_O[5:2] is constant 0 and the FIFO stores 2 bits.
  - No magnitude logic is synthesized.
- Timing and handshake are identical in both builds.

## Test plan
- Reset: assert RST_I asynchronously mid-cycle with 2 entries buffered. Outputs immediately read STB_O=0, CYC_O=0, DAT_O=0. After release, a new sample appears first and no stale symbol follows.
- Mapping: push 0x5A825A82, 0x5A82A57E, 0xA57E5A82, 0xA57EA57E, and 0x00000000 with ACK_I=1. DAT_O[1:0] must read 00, 10, 01, 11, 00, each one cycle after its ACK_O.
- Backpressure: ACK_I=0, offer 4 back-to-back samples. ACK_O is high for the first 2 only. Raise ACK_I and the remaining 2 are accepted. Output order must match input order with no duplicates or drops.
- Simultaneous push/pop at count=1: count stays 1, STB_O stays 1, and the next DAT_O is the newer sample.
- CYC drain: drop CYC_I with 2 symbols buffered and ACK_I=1. CYC_O stays 1 until the cycle after the last pop, then goes to 0.
- Soft build with QPSK_DEMOD_SOFT_EN: sample Re=0x5A82, Im=0x0800 gives DAT_O=6'b000100. Sample Re=0x8000, Im=0x7FFF gives DAT_O[5:2]=15 and DAT_O[1:0]=10. In the non-soft build, DAT_O[5:2]=0 always.
